// File: rtl/sdp_ram_tile_arbiter.sv
// ---------------------------------------------------------------------------
// sdp_ram_tile_arbiter
// Shares one simple-dual-port RAM tile between two write clients and one
// read client. The single write port is granted round-robin. When the tile
// cannot tolerate a same-cycle read/write to one address, the read is held
// off (the write wins) and each such stalled cycle is counted in a
// saturating counter. A shift register of read enables re-times the read
// issue into a response-valid strobe aligned with the tile's read data.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   wr{0,1}_valid/_addr/_data        write requests from client 0 / 1
//   wr{0,1}_ready                    write accepted this cycle
//   rd_valid/rd_addr, rd_ready       read request and acceptance
//   rsp_valid/rsp_data               read response (no backpressure)
//   ram_wr_en/_addr/_data            tile write port
//   ram_rd_en/_addr, ram_rd_data     tile read port
//   stall_count                      saturating count of collision stalls
// ---------------------------------------------------------------------------

// Requester-side obligations and arbiter invariants, observed in simulation.
module sdp_ram_tile_arbiter_chk #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  wr0_valid,
    input logic [ADDR_WIDTH-1:0] wr0_addr,
    input logic [WIDTH-1:0]      wr0_data,
    input logic                  wr0_ready,
    input logic                  wr1_valid,
    input logic [ADDR_WIDTH-1:0] wr1_addr,
    input logic [WIDTH-1:0]      wr1_data,
    input logic                  wr1_ready,
    input logic                  rd_valid,
    input logic [ADDR_WIDTH-1:0] rd_addr,
    input logic                  rd_ready
);

    a_wr0_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (wr0_valid && !wr0_ready) |=> (wr0_valid && $stable(wr0_addr) && $stable(wr0_data)));
    a_wr1_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (wr1_valid && !wr1_ready) |=> (wr1_valid && $stable(wr1_addr) && $stable(wr1_data)));
    a_rd_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (rd_valid && !rd_ready) |=> (rd_valid && $stable(rd_addr)));

    a_wr0_range: assert property (@(posedge clk) disable iff (!rst_n)
        wr0_valid |-> (int'(wr0_addr) < DEPTH));
    a_wr1_range: assert property (@(posedge clk) disable iff (!rst_n)
        wr1_valid |-> (int'(wr1_addr) < DEPTH));
    a_rd_range: assert property (@(posedge clk) disable iff (!rst_n)
        rd_valid |-> (int'(rd_addr) < DEPTH));

    a_wr0_rdy_needs_vld: assert property (@(posedge clk) disable iff (!rst_n)
        wr0_ready |-> wr0_valid);
    a_wr1_rdy_needs_vld: assert property (@(posedge clk) disable iff (!rst_n)
        wr1_ready |-> wr1_valid);
    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr0_ready && wr1_ready));

endmodule

module sdp_ram_tile_arbiter #(
    parameter int WIDTH                  = 32,
    parameter int DEPTH                  = 512,
    parameter int ADDR_WIDTH             = $clog2(DEPTH),
    parameter int RD_LATENCY             = 2,
    parameter int SUPPORTS_RW_COLLISIONS = 0,
    parameter int STALL_CNT_WIDTH        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr0_valid,
    input  logic [ADDR_WIDTH-1:0]      wr0_addr,
    input  logic [WIDTH-1:0]           wr0_data,
    output logic                       wr0_ready,
    input  logic                       wr1_valid,
    input  logic [ADDR_WIDTH-1:0]      wr1_addr,
    input  logic [WIDTH-1:0]           wr1_data,
    output logic                       wr1_ready,
    input  logic                       rd_valid,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic                       rd_ready,
    output logic                       rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       ram_wr_en,
    output logic [ADDR_WIDTH-1:0]      ram_wr_addr,
    output logic [WIDTH-1:0]           ram_wr_data,
    output logic                       ram_rd_en,
    output logic [ADDR_WIDTH-1:0]      ram_rd_addr,
    input  logic [WIDTH-1:0]           ram_rd_data,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = {STALL_CNT_WIDTH{1'b1}};
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = STALL_CNT_WIDTH'(1'b1);

    // 1 = client 1 was granted most recently; resets to 1 so client 0 wins first.
    logic                       r_last_grant;
    logic [RD_LATENCY-1:0]      r_rd_pipe;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    logic                       w_gnt0;
    logic                       w_gnt1;
    logic                       w_wr_en;
    logic [ADDR_WIDTH-1:0]      w_wr_addr;
    logic [WIDTH-1:0]           w_wr_data;
    logic                       w_collide;
    logic                       w_rd_issue;

    // Round-robin grant: a lone requester always wins, a tie goes to the
    // client that was not granted last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (wr0_valid && wr1_valid) begin
            if (r_last_grant) begin
                w_gnt0 = 1'b1;
            end else begin
                w_gnt1 = 1'b1;
            end
        end else begin
            w_gnt0 = wr0_valid;
            w_gnt1 = wr1_valid;
        end
    end

    // Write-port mux; client 0's fields are presented when nobody is granted.
    always_comb begin
        w_wr_en   = w_gnt0 | w_gnt1;
        w_wr_addr = wr0_addr;
        w_wr_data = wr0_data;
        if (w_gnt1) begin
            w_wr_addr = wr1_addr;
            w_wr_data = wr1_data;
        end else begin
            w_wr_addr = wr0_addr;
            w_wr_data = wr0_data;
        end
    end

    // Read issue: a same-address read is held off behind the write unless
    // the tile defines a collision result.
    always_comb begin
        w_collide = 1'b0;
        if (SUPPORTS_RW_COLLISIONS == 0) begin
            w_collide = rd_valid && w_wr_en && (rd_addr == w_wr_addr);
        end else begin
            w_collide = 1'b0;
        end
        w_rd_issue = rd_valid && !w_collide;
    end

    assign wr0_ready   = w_gnt0;
    assign wr1_ready   = w_gnt1;
    assign ram_wr_en   = w_wr_en;
    assign ram_wr_addr = w_wr_addr;
    assign ram_wr_data = w_wr_data;
    assign rd_ready    = w_rd_issue;
    assign ram_rd_en   = w_rd_issue;
    assign ram_rd_addr = rd_addr;
    assign rsp_valid   = r_rd_pipe[RD_LATENCY-1];
    assign rsp_data    = ram_rd_data;
    assign stall_count = r_stall_cnt;

    // Remember which client took the write port; hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_gnt0) begin
            r_last_grant <= 1'b0;
        end else if (w_gnt1) begin
            r_last_grant <= 1'b1;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    // Delay line of read issues; clearing it on reset drops in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pipe <= {RD_LATENCY{1'b0}};
        end else begin
            r_rd_pipe[0] <= w_rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
        end
    end

    // Saturating count of cycles in which a read was stalled by a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= {STALL_CNT_WIDTH{1'b0}};
        end else if (w_collide && (r_stall_cnt != STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    sdp_ram_tile_arbiter_chk #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr0_valid (wr0_valid),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr0_ready (w_gnt0),
        .wr1_valid (wr1_valid),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .wr1_ready (w_gnt1),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_ready  (w_rd_issue)
    );

endmodule

// File: tb/tb_sdp_ram_tile_arbiter.sv
// Bench for sdp_ram_tile_arbiter: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level model (grant
// rule, memory contents, response-due queue, collision count).
module tb_sdp_ram_tile_arbiter;

    localparam int W  = 32;
    localparam int D  = 512;
    localparam int AW = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          wr0_valid, wr1_valid, rd_valid;
    logic [AW-1:0] wr0_addr, wr1_addr, rd_addr;
    logic [W-1:0]  wr0_data, wr1_data;

    logic          wr0_ready, wr1_ready, rd_ready, rsp_valid;
    logic [W-1:0]  rsp_data, ram_wr_data, ram_rd_data;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [15:0]   stall_count;

    logic          d2_wr0_ready, d2_wr1_ready, d2_rd_ready, d2_rsp_valid;
    logic [W-1:0]  d2_rsp_data, d2_ram_wr_data;
    logic          d2_ram_wr_en, d2_ram_rd_en;
    logic [AW-1:0] d2_ram_wr_addr, d2_ram_rd_addr;
    logic [1:0]    d2_stall_count;

    sdp_ram_tile_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
        .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .stall_count(stall_count)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    sdp_ram_tile_arbiter #(.STALL_CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(d2_wr0_ready),
        .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(d2_wr1_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(d2_rd_ready),
        .rsp_valid(d2_rsp_valid), .rsp_data(d2_rsp_data),
        .ram_wr_en(d2_ram_wr_en), .ram_wr_addr(d2_ram_wr_addr), .ram_wr_data(d2_ram_wr_data),
        .ram_rd_en(d2_ram_rd_en), .ram_rd_addr(d2_ram_rd_addr), .ram_rd_data(ram_rd_data),
        .stall_count(d2_stall_count)
    );

    // RAM tile with output register: data appears two cycles after rd_en.
    logic [W-1:0] tile_mem [0:D-1];
    logic [W-1:0] tile_q1, tile_q2;
    always @(posedge clk) begin
        if (ram_wr_en) tile_mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) tile_q1 <= tile_mem[ram_rd_addr];
        tile_q2 <= tile_q1;
    end
    assign ram_rd_data = tile_q2;

    // Reference model state
    typedef struct { int due; logic [W-1:0] data; bit known; } rsp_t;
    rsp_t          q[$];
    logic [W-1:0]  m_mem   [0:D-1];
    bit            m_known [0:D-1];
    int            m_last, m_stall, cyc;
    bit            e_g0, e_g1, e_wen, e_coll, e_rrdy, e_rsp;
    logic [AW-1:0] e_waddr;
    logic [W-1:0]  e_wdata;
    int            n_checks, n_fail;
    int            exp_seq [0:3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input bit v0, input int a0, input logic [W-1:0] d0,
                         input bit v1, input int a1, input logic [W-1:0] d1,
                         input bit rv, input int ra);
        wr0_valid = v0; wr0_addr = AW'(a0); wr0_data = d0;
        wr1_valid = v1; wr1_addr = AW'(a1); wr1_data = d1;
        rd_valid  = rv; rd_addr  = AW'(ra);
    endtask

    // Predict this cycle's outputs from the rules and compare both instances.
    task automatic eval_and_check();
        int s1, s2;
        @(negedge clk);
        e_g0 = 1'b0; e_g1 = 1'b0;
        if (wr0_valid && wr1_valid) begin
            if (m_last == 1) e_g0 = 1'b1; else e_g1 = 1'b1;
        end else if (wr0_valid) e_g0 = 1'b1;
        else if (wr1_valid)     e_g1 = 1'b1;
        e_wen   = e_g0 || e_g1;
        e_waddr = e_g1 ? wr1_addr : wr0_addr;
        e_wdata = e_g1 ? wr1_data : wr0_data;
        e_coll  = rd_valid && e_wen && (rd_addr == e_waddr);
        e_rrdy  = rd_valid && !e_coll;
        e_rsp   = (q.size() > 0) && (q[0].due == cyc);
        s1 = (m_stall > 65535) ? 65535 : m_stall;
        s2 = (m_stall > 3) ? 3 : m_stall;
        check("wr0_ready", wr0_ready, e_g0);
        check("wr1_ready", wr1_ready, e_g1);
        check("ram_wr_en", ram_wr_en, e_wen);
        check("ram_wr_addr", ram_wr_addr, e_waddr);
        check("ram_wr_data", ram_wr_data, e_wdata);
        check("rd_ready", rd_ready, e_rrdy);
        check("ram_rd_en", ram_rd_en, e_rrdy);
        check("ram_rd_addr", ram_rd_addr, rd_addr);
        check("rsp_valid", rsp_valid, e_rsp);
        check("stall_count", stall_count, s1);
        check("d2_wr0_ready", d2_wr0_ready, e_g0);
        check("d2_wr1_ready", d2_wr1_ready, e_g1);
        check("d2_ram_wr_en", d2_ram_wr_en, e_wen);
        check("d2_ram_wr_addr", d2_ram_wr_addr, e_waddr);
        check("d2_ram_wr_data", d2_ram_wr_data, e_wdata);
        check("d2_rd_ready", d2_rd_ready, e_rrdy);
        check("d2_ram_rd_en", d2_ram_rd_en, e_rrdy);
        check("d2_ram_rd_addr", d2_ram_rd_addr, rd_addr);
        check("d2_rsp_valid", d2_rsp_valid, e_rsp);
        check("d2_stall_count", d2_stall_count, s2);
        if (e_rsp) begin
            if (q[0].known) begin
                check("rsp_data", rsp_data, q[0].data);
                check("d2_rsp_data", d2_rsp_data, q[0].data);
            end
            void'(q.pop_front());
        end
    endtask

    // Commit the predicted transactions and move to the next cycle.
    task automatic advance();
        if (e_rrdy) q.push_back('{cyc + 2, m_mem[rd_addr], m_known[rd_addr]});
        if (e_wen) begin
            m_mem[e_waddr]   = e_wdata;
            m_known[e_waddr] = 1'b1;
        end
        if (e_g0) m_last = 0;
        if (e_g1) m_last = 1;
        if (e_coll) m_stall++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        drive(0, 0, '0, 0, 0, '0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_stall", stall_count, 16'd0);
        check("rst_d2_rsp_valid", d2_rsp_valid, 1'b0);
        check("rst_d2_stall", d2_stall_count, 2'd0);
        q.delete();
        m_last  = 1;
        m_stall = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; m_last = 1; m_stall = 0;
        for (int i = 0; i < D; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = '0;
        end
        exp_seq[0] = 3; exp_seq[1] = 7; exp_seq[2] = 3; exp_seq[3] = 7;
        reset_dut();

        // Idle after reset release
        drive(0, 0, '0, 0, 0, '0, 0, 0);
        eval_and_check();
        check("idle_wr_en", ram_wr_en, 1'b0);
        check("idle_rd_en", ram_rd_en, 1'b0);
        advance();

        // Both writers contending: grants alternate, client 0 first
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 32'hA0A0_0003, 1, 7, 32'hB1B1_0007, 0, 0);
            eval_and_check();
            check("rr_addr", ram_wr_addr, exp_seq[i]);
            check("rr_gnt0", wr0_ready, (i % 2) == 0);
            advance();
        end
        drive(1, 3, 32'hA0A0_0003, 0, 0, '0, 0, 0);
        eval_and_check();
        advance();

        // Write then read back with two-cycle latency
        drive(1, 5, 32'hDEAD_BEEF, 0, 0, '0, 0, 0);
        eval_and_check(); advance();
        drive(0, 0, '0, 0, 0, '0, 0, 0);
        eval_and_check(); advance();
        drive(0, 0, '0, 0, 0, '0, 1, 5);
        eval_and_check();
        check("rd5_ready", rd_ready, 1'b1);
        advance();
        drive(0, 0, '0, 0, 0, '0, 0, 0);
        eval_and_check();
        check("rd5_early", rsp_valid, 1'b0);
        advance();
        eval_and_check();
        check("rd5_rsp_valid", rsp_valid, 1'b1);
        check("rd5_rsp_data", rsp_data, 32'hDEAD_BEEF);
        advance();

        // Same-address read stalls behind three writes
        for (int i = 0; i < 3; i++) begin
            drive(1, 9, 32'h9999_0000 + W'(i), 0, 0, '0, 1, 9);
            eval_and_check();
            check("coll_rd_ready", rd_ready, 1'b0);
            advance();
        end
        drive(0, 0, '0, 0, 0, '0, 1, 9);
        eval_and_check();
        check("coll_rd_issue", rd_ready, 1'b1);
        advance();
        drive(0, 0, '0, 0, 0, '0, 0, 0);
        eval_and_check();
        check("stall3", stall_count, 16'd3);
        advance();
        eval_and_check();
        check("coll_rsp_data", rsp_data, 32'h9999_0002);
        advance();

        // Narrow counter saturates at 3 after six collisions
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, '0, 1, 12, 32'h1200_0000 + W'(i), 1, 12);
            eval_and_check();
            advance();
        end
        drive(0, 0, '0, 0, 0, '0, 1, 12);
        eval_and_check();
        check("sat_d2", d2_stall_count, 2'd3);
        check("sat_d1", stall_count, 16'd6);
        advance();
        drive(0, 0, '0, 0, 0, '0, 0, 0);
        repeat (3) begin eval_and_check(); advance(); end

        // Reset with reads in flight drops their responses
        drive(0, 0, '0, 0, 0, '0, 1, 3); eval_and_check(); advance();
        drive(0, 0, '0, 0, 0, '0, 1, 7); eval_and_check(); advance();
        drive(0, 0, '0, 0, 0, '0, 1, 5); eval_and_check(); advance();
        drive(0, 0, '0, 0, 0, '0, 0, 0);
        eval_and_check();
        check("inflight_rsp", rsp_valid, 1'b1);
        reset_dut();
        repeat (4) begin eval_and_check(); advance(); end
        drive(1, 1, 32'h0101_0101, 1, 2, 32'h0202_0202, 0, 0);
        eval_and_check();
        check("post_rst_gnt0", wr0_ready, 1'b1);
        check("post_rst_gnt1", wr1_ready, 1'b0);
        advance();
        drive(0, 0, '0, 1, 2, 32'h0202_0202, 0, 0);
        eval_and_check(); advance();

        // Random traffic on a small address window to provoke collisions
        drive(0, 0, '0, 0, 0, '0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            if (!(wr0_valid && !e_g0)) begin
                wr0_valid = ($urandom_range(0, 9) < 6);
                wr0_addr  = AW'($urandom_range(0, 15));
                wr0_data  = $urandom;
            end
            if (!(wr1_valid && !e_g1)) begin
                wr1_valid = ($urandom_range(0, 9) < 6);
                wr1_addr  = AW'($urandom_range(0, 15));
                wr1_data  = $urandom;
            end
            if (!(rd_valid && !e_rrdy)) begin
                rd_valid = ($urandom_range(0, 9) < 6);
                rd_addr  = AW'($urandom_range(0, 15));
            end
            eval_and_check();
            advance();
        end
        // Let pending requests complete, then drain responses
        for (int n = 0; n < 10; n++) begin
            if (!(wr0_valid && !e_g0)) wr0_valid = 1'b0;
            if (!(wr1_valid && !e_g1)) wr1_valid = 1'b0;
            if (!(rd_valid && !e_rrdy)) rd_valid = 1'b0;
            eval_and_check();
            advance();
        end
        check("drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
